// File: rtl/my_dmux16_reg_if.sv
// Handshake bundle for the registered 16-bit 1-to-2 demultiplexer.
// The slave modport is the demux itself; the master modport is its environment.
interface my_dmux16_reg_if;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic        sel;
    logic        alt;
    logic [15:0] out1;
    logic [15:0] out2;
    logic        out1_valid;
    logic        out2_valid;
    logic        out1_ready;
    logic        out2_ready;
    logic [7:0]  cnt1;
    logic [7:0]  cnt2;

    modport slave (
        input  in, in_valid, sel, alt, out1_ready, out2_ready,
        output in_ready, out1, out2, out1_valid, out2_valid, cnt1, cnt2
    );

    modport master (
        output in, in_valid, sel, alt, out1_ready, out2_ready,
        input  in_ready, out1, out2, out1_valid, out2_valid, cnt1, cnt2
    );
endinterface

// File: rtl/my_dmux16_reg.sv
// Registered 1-to-2 demultiplexer: each accepted word lands in one of two
// single-entry channel registers, chosen by sel or by an alternating pointer.
module my_dmux16_reg (
    input  logic              clk,
    input  logic              rst_n,
    my_dmux16_reg_if.slave    bus
);

    logic [15:0] data1_q, data1_d;
    logic [15:0] data2_q, data2_d;
    logic        full1_q, full1_d;
    logic        full2_q, full2_d;
    logic [7:0]  cnt1_q, cnt1_d;
    logic [7:0]  cnt2_q, cnt2_d;
    logic        tog_q, tog_d;
    logic        dst_s;
    logic        in_ready_s;
    logic        accept_s;

    // Destination select and ready; ready looks only at the chosen channel.
    always_comb begin
        dst_s      = bus.alt ? tog_q : bus.sel;
        in_ready_s = 1'b0;
        if (dst_s) begin
            in_ready_s = !full2_q || bus.out2_ready;
        end else begin
            in_ready_s = !full1_q || bus.out1_ready;
        end
        accept_s = bus.in_valid && in_ready_s;
    end

    // Next-state: a load into a channel overrides its drain in the same cycle.
    always_comb begin
        data1_d = data1_q;
        data2_d = data2_q;
        full1_d = full1_q;
        full2_d = full2_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        tog_d   = tog_q;

        if (full1_q && bus.out1_ready) begin
            full1_d = 1'b0;
        end else begin
            full1_d = full1_q;
        end
        if (full2_q && bus.out2_ready) begin
            full2_d = 1'b0;
        end else begin
            full2_d = full2_q;
        end

        if (accept_s && !dst_s) begin
            data1_d = bus.in;
            full1_d = 1'b1;
            cnt1_d  = cnt1_q + 8'd1;
        end else if (accept_s && dst_s) begin
            data2_d = bus.in;
            full2_d = 1'b1;
            cnt2_d  = cnt2_q + 8'd1;
        end else begin
            cnt1_d  = cnt1_q;
            cnt2_d  = cnt2_q;
        end

        if (accept_s && bus.alt) begin
            tog_d = ~tog_q;
        end else begin
            tog_d = tog_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data1_q <= 16'h0000;
            data2_q <= 16'h0000;
            full1_q <= 1'b0;
            full2_q <= 1'b0;
            cnt1_q  <= 8'h00;
            cnt2_q  <= 8'h00;
            tog_q   <= 1'b0;
        end else begin
            data1_q <= data1_d;
            data2_q <= data2_d;
            full1_q <= full1_d;
            full2_q <= full2_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            tog_q   <= tog_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out1       = data1_q;
    assign bus.out2       = data2_q;
    assign bus.out1_valid = full1_q;
    assign bus.out2_valid = full2_q;
    assign bus.cnt1       = cnt1_q;
    assign bus.cnt2       = cnt2_q;

endmodule
